// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 2-flop input synchronizer, one-cycle valid/err strobes.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 (even parity bit after bit 7).
module uart_rx #(
  parameter int unsigned clkFreq  = 48_000_000,
  parameter int unsigned baudRate = 9600
) (
  input  logic       clkIN,
  input  logic       nResetIN,
  input  logic       rxIN,
  output logic [7:0] dataOUT,
  output logic       validOUT,
  output logic       errOUT,
  output logic       nBusyOUT
);

  localparam int unsigned BIT_CYC  = clkFreq / baudRate;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               nbusy_q, nbusy_d;
  logic               last_cnt, half_cnt;
`ifdef UART_RX_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  assign dataOUT  = data_q;
  assign validOUT = valid_q;
  assign errOUT   = err_q;
  assign nBusyOUT = nbusy_q;

  // START lasts HALF_CYC-1 cycles so the start sample lands at edge + 2 + HALF_CYC
  assign last_cnt = (cnt_q == CNT_W'(BIT_CYC - 1));
  assign half_cnt = (cnt_q == CNT_W'(HALF_CYC - 2));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (half_cnt) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (last_cnt) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (last_cnt) begin
          cnt_d     = '0;
          par_err_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_err_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // a held-low line (break) must not be decoded as a stream of 0x00 frames
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    nbusy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      nbusy_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rxIN;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      nbusy_q   <= nbusy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at clkFreq=16, baudRate=1 (16 clocks per bit).
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 154 + BIT;
`else
  localparam int LAT = 154;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, err_o, nbusy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = 0;
  logic par_flip = 1'b0;

  logic [7:0] vq[$];
  int         vcyc[$];
  int         err_cnt = 0;
  int         both_cnt = 0;

  always #5 clk = ~clk;

  uart_rx #(.clkFreq(16), .baudRate(1)) dut (
    .clkIN(clk), .nResetIN(rst_n), .rxIN(rx),
    .dataOUT(data_o), .validOUT(valid_o), .errOUT(err_o), .nBusyOUT(nbusy_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (valid_o) begin
      vq.push_back(data_o);
      vcyc.push_back(cyc);
    end
    if (err_o) err_cnt++;
    if (valid_o && err_o) both_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = i[0];
      wait_cyc(1);
    end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL reset_nbusy: got %b want 1", nbusy_o); end
    rx = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(40);
    n_cmp++; if (vq.size() !== 0) begin n_bad++; $display("FAIL reset_idle_valid: got %0d pulses want 0", vq.size()); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL reset_idle_err: got %0d pulses want 0", err_cnt); end
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL reset_idle_nbusy: got %b want 1", nbusy_o); end
  endtask

  task automatic test_nominal();
    int base, e0, lat;
    base = vq.size();
    e0 = err_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_cyc(80);
        n_cmp++; if (nbusy_o !== 1'b0) begin n_bad++; $display("FAIL nominal_busy: got %b want 0", nbusy_o); end
      end
    join
    wait_cyc(8);
    n_cmp++; if (vq.size() - base !== 1) begin n_bad++; $display("FAIL nominal_count: got %0d want 1", vq.size() - base); end
    if (vq.size() > base) begin
      // t_start is the cycle in which the start edge was driven
      lat = vcyc[base] - t_start;
      n_cmp++; if (vq[base] !== 8'h55) begin n_bad++; $display("FAIL nominal_data: got %h want 55", vq[base]); end
      n_cmp++; if (lat < LAT - 1 || lat > LAT + 1) begin n_bad++; $display("FAIL nominal_latency: got %0d want %0d+-1", lat, LAT); end
    end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL nominal_err: got %0d want %0d", err_cnt, e0); end
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL nominal_idle: got %b want 1", nbusy_o); end
  endtask

  task automatic test_back_to_back();
    int base, e0;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA3; exp_d[1] = 8'h00; exp_d[2] = 8'hFF;
    base = vq.size();
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1);
    wait_cyc(8);
    n_cmp++; if (vq.size() - base !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", vq.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (vq.size() > base + i) begin
        n_cmp++; if (vq[base+i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, vq[base+i], exp_d[i]); end
      end
    end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL b2b_err: got %0d want %0d", err_cnt, e0); end
  endtask

  task automatic test_glitch();
    int base, e0;
    base = vq.size();
    e0 = err_cnt;
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(6);
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL glitch_nbusy: got %b want 1", nbusy_o); end
    wait_cyc(20);
    n_cmp++; if (vq.size() !== base) begin n_bad++; $display("FAIL glitch_valid: got %0d want %0d", vq.size(), base); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL glitch_err: got %0d want %0d", err_cnt, e0); end
    send_frame(8'h3C, 1'b1);
    wait_cyc(8);
    n_cmp++; if (vq.size() - base !== 1) begin n_bad++; $display("FAIL glitch_frame_count: got %0d want 1", vq.size() - base); end
    n_cmp++; if (data_o !== 8'h3C) begin n_bad++; $display("FAIL glitch_frame_data: got %h want 3c", data_o); end
  endtask

  task automatic test_framing();
    int base, e0;
    base = vq.size();
    e0 = err_cnt;
    send_frame(8'h81, 1'b0);
    wait_cyc(36);
    n_cmp++; if (nbusy_o !== 1'b0) begin n_bad++; $display("FAIL frame_busy: got %b want 0", nbusy_o); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL frame_err: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (data_o !== 8'h3C) begin n_bad++; $display("FAIL frame_data_hold: got %h want 3c", data_o); end
    rx = 1'b1;
    wait_cyc(6);
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL frame_release: got %b want 1", nbusy_o); end
    wait_cyc(20);
    n_cmp++; if (vq.size() !== base) begin n_bad++; $display("FAIL frame_no_valid: got %0d want %0d", vq.size(), base); end
  endtask

  task automatic test_reset_mid_frame();
    int base, e0;
    logic [7:0] d;
    d = 8'h96;
    base = vq.size();
    e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", data_o); end
    n_cmp++; if (nbusy_o !== 1'b1) begin n_bad++; $display("FAIL midrst_nbusy: got %b want 1", nbusy_o); end
    rx = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(40);
    n_cmp++; if (vq.size() !== base) begin n_bad++; $display("FAIL midrst_no_valid: got %0d want %0d", vq.size(), base); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL midrst_no_err: got %0d want %0d", err_cnt, e0); end
    send_frame(8'h96, 1'b1);
    wait_cyc(8);
    n_cmp++; if (vq.size() - base !== 1) begin n_bad++; $display("FAIL midrst_clean_count: got %0d want 1", vq.size() - base); end
    n_cmp++; if (data_o !== 8'h96) begin n_bad++; $display("FAIL midrst_clean_data: got %h want 96", data_o); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base, e0;
    base = vq.size();
    e0 = err_cnt;
    par_flip = 1'b1;
    send_frame(8'h5A, 1'b1);
    par_flip = 1'b0;
    wait_cyc(8);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_bad_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (vq.size() !== base) begin n_bad++; $display("FAIL parity_bad_valid: got %0d want %0d", vq.size(), base); end
    n_cmp++; if (data_o !== 8'h96) begin n_bad++; $display("FAIL parity_bad_hold: got %h want 96", data_o); end
    send_frame(8'h69, 1'b1);
    wait_cyc(8);
    n_cmp++; if (vq.size() - base !== 1) begin n_bad++; $display("FAIL parity_good_count: got %0d want 1", vq.size() - base); end
    n_cmp++; if (data_o !== 8'h69) begin n_bad++; $display("FAIL parity_good_data: got %h want 69", data_o); end
  endtask
`endif

  task automatic test_exclusive();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
